// File: rtl/affine_to_jacobian.sv
// Affine -> Jacobian conversion for secp256k1 with a random-Z blinding option.
// Blinding is built only when AFFINE_TO_JACOBIAN_BLIND_EN is defined; otherwise (x, y) -> (x, y, 1).

module mod_mul (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         done,
  output logic [255:0] result
);
  localparam logic [256:0] P = {1'b0, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F};

  logic [255:0] a_q, b_q, acc_q, acc_d;
  logic [8:0]   cnt_q;
  logic         run_q, done_q;
  logic [256:0] dbl, dbl_r, sum, sum_r;

  // MSB-first double-and-add; each partial stays below P, so one conditional subtract suffices
  always_comb begin
    dbl   = {acc_q, 1'b0};
    dbl_r = (dbl >= P) ? dbl - P : dbl;
    sum   = dbl_r + {1'b0, a_q};
    sum_r = (sum >= P) ? sum - P : sum;
    acc_d = b_q[255] ? sum_r[255:0] : dbl_r[255:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        acc_q <= '0;
        cnt_q <= 9'd256;
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= acc_d;
        b_q   <= {b_q[254:0], 1'b0};
        cnt_q <= cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done   = done_q;
  assign result = acc_q;
endmodule

module affine_to_jacobian (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] x_affine,
  input  logic [255:0] y_affine,
  input  logic [255:0] z_rand,
  output logic [255:0] Xj,
  output logic [255:0] Yj,
  output logic [255:0] Zj,
  output logic         busy,
  output logic         done,
  output logic         z_fixup
);
  typedef enum logic [2:0] {IDLE, SQ, CU, MX, MY, FIN} state_t;

  state_t       state_q, state_d;
  logic [255:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [255:0] Xj_q, Xj_d, Yj_q, Yj_d, Zj_q, Zj_d;
  logic         busy_q, busy_d, done_q, done_d, fix_q, fix_d;

`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
  logic [255:0] z2_q, z2_d, z3_q, z3_d;
  logic [255:0] mul_a, mul_b, mul_res;
  logic         mst_q, mst_d, mul_done, mul_ack;

  mod_mul u_mul (
    .clk    (clk),
    .rst    (~rst_n),
    .start  (mst_q),
    .a      (mul_a),
    .b      (mul_b),
    .done   (mul_done),
    .result (mul_res)
  );

  // a done coinciding with our own start pulse cannot belong to this request
  assign mul_ack = mul_done && !mst_q;
`else
  logic unused_z;
  assign unused_z = ^z_rand;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    Xj_d    = Xj_q;
    Yj_d    = Yj_q;
    Zj_d    = Zj_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fix_d   = fix_q;
`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
    z2_d    = z2_q;
    z3_d    = z3_q;
    mst_d   = 1'b0;
    mul_a   = z_q;
    mul_b   = z_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        fix_d  = 1'b0;
        if (x_affine == '0 && y_affine == '0) begin
          x_d     = 256'd1;
          y_d     = 256'd1;
          z_d     = '0;
          state_d = FIN;
        end else begin
          x_d = x_affine;
          y_d = y_affine;
`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
          z_d     = (z_rand == '0) ? 256'd1 : z_rand;
          fix_d   = (z_rand == '0);
          mst_d   = 1'b1;
          state_d = SQ;
`else
          z_d     = 256'd1;
          state_d = FIN;
`endif
        end
      end
`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
      SQ: begin
        mul_a = z_q;
        mul_b = z_q;
        if (mul_ack) begin
          z2_d    = mul_res;
          mst_d   = 1'b1;
          state_d = CU;
        end
      end
      CU: begin
        mul_a = z2_q;
        mul_b = z_q;
        if (mul_ack) begin
          z3_d    = mul_res;
          mst_d   = 1'b1;
          state_d = MX;
        end
      end
      MX: begin
        mul_a = x_q;
        mul_b = z2_q;
        if (mul_ack) begin
          x_d     = mul_res;
          mst_d   = 1'b1;
          state_d = MY;
        end
      end
      MY: begin
        mul_a = y_q;
        mul_b = z3_q;
        if (mul_ack) begin
          y_d     = mul_res;
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        // results land on the outputs together with done
        Xj_d    = x_q;
        Yj_d    = y_q;
        Zj_d    = z_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      Xj_q    <= '0;
      Yj_q    <= '0;
      Zj_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fix_q   <= 1'b0;
`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
      z2_q    <= '0;
      z3_q    <= '0;
      mst_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      Xj_q    <= Xj_d;
      Yj_q    <= Yj_d;
      Zj_q    <= Zj_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fix_q   <= fix_d;
`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
      z2_q    <= z2_d;
      z3_q    <= z3_d;
      mst_q   <= mst_d;
`endif
    end
  end

  assign Xj      = Xj_q;
  assign Yj      = Yj_q;
  assign Zj      = Zj_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign z_fixup = fix_q;
endmodule

// File: tb/tb_affine_to_jacobian.sv
// Directed bench for affine_to_jacobian; expectations follow the build (blinded or pass-through).
// Latencies count rising edges from the start-sampling edge to the edge that raises done.

module tb_affine_to_jacobian;
  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
`ifdef AFFINE_TO_JACOBIAN_BLIND_EN
  localparam bit BLIND = 1'b1;
`else
  localparam bit BLIND = 1'b0;
`endif
  localparam int LM     = 257;                         // mod_mul: start cycle to done cycle
  localparam int LAT_N  = BLIND ? 4*(LM+1)+1 : 1;
  localparam int LAT_I  = 1;                           // done visible when edge 2 samples it
  localparam int SEC_AT = BLIND ? 600 : 0;             // lands inside MX (edges 516..773)
  localparam int RST_AT = BLIND ? 300 : 0;             // lands inside CU (edges 258..515)

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] x_affine = '0, y_affine = '0, z_rand = '0;
  logic [255:0] Xj, Yj, Zj;
  logic         busy, done, z_fixup;

  int n_chk = 0;
  int n_pass = 0;

  affine_to_jacobian dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_affine(x_affine), .y_affine(y_affine), .z_rand(z_rand),
    .Xj(Xj), .Yj(Yj), .Zj(Zj),
    .busy(busy), .done(done), .z_fixup(z_fixup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // issue one request, scramble the input ports afterwards, wait (bounded) for done
  task automatic convert(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                         output int lat, output bit busy_ok);
    @(negedge clk);
    x_affine = x; y_affine = y; z_rand = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x_affine = 256'hBAD0; y_affine = 256'hBAD1; z_rand = 256'hBAD2;
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 4000) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_case(input string t, input logic [255:0] x, input logic [255:0] y,
                          input logic [255:0] z, input logic [255:0] ex, input logic [255:0] ey,
                          input logic [255:0] ez, input logic efix, input int elat);
    int lat;
    bit bok;
    convert(x, y, z, lat, bok);
    chk({t, ".lat"}, lat, elat);
    chk({t, ".busy_during"}, {255'd0, bok}, 256'd1);
    chk({t, ".busy_at_done"}, {255'd0, busy}, 256'd0);
    chk({t, ".Xj"}, Xj, ex);
    chk({t, ".Yj"}, Yj, ey);
    chk({t, ".Zj"}, Zj, ez);
    chk({t, ".z_fixup"}, {255'd0, z_fixup}, {255'd0, efix});
    @(posedge clk); #1;
    chk({t, ".done_pulse"}, {255'd0, done}, 256'd0);
  endtask

  initial begin
    int ndone;
    logic [255:0] cx, cy, cz;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.Xj", Xj, 256'd0);
    chk("rst.Yj", Yj, 256'd0);
    chk("rst.Zj", Zj, 256'd0);
    chk("rst.busy", {255'd0, busy}, 256'd0);
    chk("rst.done", {255'd0, done}, 256'd0);
    chk("rst.z_fixup", {255'd0, z_fixup}, 256'd0);
    rst_n = 1'b1;

    run_case("basic", 256'd2, 256'd3, 256'd5,
             BLIND ? 256'd50 : 256'd2, BLIND ? 256'd375 : 256'd3, BLIND ? 256'd5 : 256'd1,
             1'b0, LAT_N);
    // z = P-1: z^2 = 1, z^3 = P-1, so Y = 11*(P-1) = P-11 mod P
    run_case("modP", 256'd7, 256'd11, P - 256'd1,
             256'd7, BLIND ? P - 256'd11 : 256'd11, BLIND ? P - 256'd1 : 256'd1,
             1'b0, LAT_N);
    run_case("inf", 256'd0, 256'd0, 256'd123, 256'd1, 256'd1, 256'd0, 1'b0, LAT_I);
    run_case("zfix", 256'd4, 256'd9, 256'd0, 256'd4, 256'd9, 256'd1, BLIND, LAT_N);
    run_case("z3", 256'd4, 256'd9, 256'd3,
             BLIND ? 256'd36 : 256'd4, BLIND ? 256'd243 : 256'd9, BLIND ? 256'd3 : 256'd1,
             1'b0, LAT_N);

    // second start while busy must be dropped
    @(negedge clk);
    x_affine = 256'd2; y_affine = 256'd3; z_rand = 256'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (SEC_AT) @(posedge clk);
    #1;
    x_affine = 256'd99; y_affine = 256'd98; z_rand = 256'd97; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; cx = '0; cy = '0; cz = '0;
    for (int i = 0; i < LAT_N + 20; i++) begin
      if (done) begin
        ndone++;
        cx = Xj; cy = Yj; cz = Zj;
      end
      @(posedge clk); #1;
    end
    chk("ign.ndone", ndone, 256'd1);
    chk("ign.Xj", cx, BLIND ? 256'd50 : 256'd2);
    chk("ign.Yj", cy, BLIND ? 256'd375 : 256'd3);
    chk("ign.Zj", cz, BLIND ? 256'd5 : 256'd1);
    chk("ign.busy", {255'd0, busy}, 256'd0);

    // one-cycle reset in the middle of a conversion
    @(negedge clk);
    x_affine = 256'd4; y_affine = 256'd9; z_rand = 256'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RST_AT) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst.Xj", Xj, 256'd0);
    chk("mrst.Yj", Yj, 256'd0);
    chk("mrst.Zj", Zj, 256'd0);
    chk("mrst.busy", {255'd0, busy}, 256'd0);
    chk("mrst.done", {255'd0, done}, 256'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst.idle_busy", {255'd0, busy}, 256'd0);
    run_case("after_rst", 256'd2, 256'd3, 256'd5,
             BLIND ? 256'd50 : 256'd2, BLIND ? 256'd375 : 256'd3, BLIND ? 256'd5 : 256'd1,
             1'b0, LAT_N);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
